// File: rtl/ram_stream_fifo_ctrl.sv
// Streaming FIFO controller around a one-cycle-latency dual-port RAM.
// Port 1 writes, port 2 reads; a 2-entry prefetch buffer gives first-word-fall-through output.
module ram_stream_fifo_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 14,
    parameter int AFULL_TH = 2**ADDR_W - 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ram_data1,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic              ram_w_en1,
    output logic [DATA_W-1:0] ram_data2,
    output logic [ADDR_W-1:0] ram_addr2,
    output logic              ram_w_en2,
    input  logic [DATA_W-1:0] ram_q2,
    output logic [ADDR_W+1:0] fill_level,
    output logic              almost_full
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   RAM_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W+1:0] AFULL_LV = (ADDR_W+2)'(AFULL_TH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_count;
    logic              inflight;
    logic [1:0]        out_count;
    logic [DATA_W-1:0] obuf [2];

    logic              accept;
    logic              pop;
    logic              issue;
    logic [2:0]        occupancy;
    logic [ADDR_W+1:0] fill_next;

    // Holding in_ready low during reset keeps a producer from seeing a stale handshake.
    assign in_ready  = rst_n && (ram_count != RAM_FULL);
    assign accept    = in_valid && in_ready;
    assign out_valid = (out_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // Buffer slots committed after this edge; pop is only true with out_count >= 1, so no underflow.
    assign occupancy = {1'b0, out_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (ram_count != '0) && (occupancy < 3'd2);

    assign fill_next = fill_level + (ADDR_W+2)'(accept) - (ADDR_W+2)'(pop);

    assign ram_data1 = in_data;
    assign ram_addr1 = wr_ptr;
    assign ram_w_en1 = accept;
    assign ram_data2 = '0;
    assign ram_addr2 = rd_ptr;
    assign ram_w_en2 = 1'b0;
    assign out_data  = obuf[0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            inflight    <= 1'b0;
            fill_level  <= '0;
            almost_full <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (issue)  rd_ptr <= rd_ptr + 1'b1;
            case ({accept, issue})
                2'b10:   ram_count <= ram_count + 1'b1;
                2'b01:   ram_count <= ram_count - 1'b1;
                default: ram_count <= ram_count;
            endcase
            inflight    <= issue;
            fill_level  <= fill_next;
            almost_full <= (fill_next >= AFULL_LV);
        end
    end

    // NOTE: the two buffer words are plain flops, so they are reset to keep out_data at 0 after reset;
    // the RAM array itself is never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= 2'd0;
            obuf[0]   <= '0;
            obuf[1]   <= '0;
        end else if (pop && inflight) begin
            if (out_count == 2'd1) begin
                obuf[0] <= ram_q2;
            end else begin
                obuf[0] <= obuf[1];
                obuf[1] <= ram_q2;
            end
        end else if (pop) begin
            obuf[0]   <= obuf[1];
            out_count <= out_count - 2'd1;
        end else if (inflight) begin
            if (out_count == 2'd0) obuf[0] <= ram_q2;
            else                   obuf[1] <= ram_q2;
            out_count <= out_count + 2'd1;
        end
    end

endmodule

// File: doc/ram_stream_fifo_ctrl.md
Name: ram_stream_fifo_ctrl

Overview:
- Streaming FIFO controller placed directly upstream and downstream of the 16-bit dual-port RAM (14-bit address per port, 16384 words).
- Drives port 1 as the write port and port 2 as the read port.
- Prefetches RAM data into a 2-entry output buffer, so the consumer sees first-word-fall-through valid/ready at one word per cycle.
- Converts the RAM's raw one-cycle-latency port into a backpressured stream for producer and consumer stages.

Parameters:
DATA_W, 16, word width; must match RAM data width.
ADDR_W, 14, RAM address width; RAM depth = 2**ADDR_W.
AFULL_TH, 2**ADDR_W-4, fill_level at or above which almost_full asserts.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  DATA_W  write-stream data.
in_valid  in  1  producer has data.
in_ready  out  1  controller accepts data this cycle.
out_data  out  DATA_W  head-of-FIFO data.
out_valid  out  1  out_data valid.
out_ready  in  1  consumer takes out_data this cycle.
ram_data1  out  DATA_W  RAM port-1 write data (= in_data).
ram_addr1  out  ADDR_W  RAM port-1 address (= wr_ptr).
ram_w_en1  out  1  RAM port-1 write enable.
ram_data2  out  DATA_W  tied 0.
ram_addr2  out  ADDR_W  RAM port-2 address (= rd_ptr).
ram_w_en2  out  1  tied 0; port 2 is read-only.
ram_q2  in  DATA_W  RAM port-2 read data, valid the cycle after the address edge.
fill_level  out  ADDR_W+2  total words held (RAM + in flight + output buffer).
almost_full  out  1  fill_level >= AFULL_TH.

Behaviour:
- Clock is clk. Reset is asynchronous, active-low, on rst_n.
- Reset clears wr_ptr, rd_ptr, ram_count, inflight, out_count, buffer contents and fill_level to 0.
- Reset outputs: out_valid=0, out_data=0, ram_w_en1=0, almost_full=0, in_ready=0 while rst_n low. in_ready is 1 after reset release.
- RAM contents are not cleared; they are treated as stale.
- State registers:
  - wr_ptr, rd_ptr: ADDR_W bits each, natural wrap at 2**ADDR_W.
  - ram_count: ADDR_W+1 bits, words written to RAM but not yet read-issued.
  - inflight: 1 bit, read issued last edge.
  - out_count: 0..2 entries in the output buffer.
- Write:
  - in_ready = (ram_count != 2**ADDR_W).
  - accept = in_valid & in_ready; ram_w_en1 = accept (combinational).
  - On an accept edge: RAM captures in_data at wr_ptr; wr_ptr+1; ram_count+1.
- Read issue:
  - pop = out_valid & out_ready.
  - issue = (ram_count != 0) & (out_count + inflight - pop < 2). issue is combinational from out_ready.
  - On an issue edge: RAM samples rd_ptr; rd_ptr+1; ram_count-1; inflight<=1. Otherwise inflight<=0.
  - Simultaneous accept and issue: ram_count unchanged.
- Capture: when inflight=1, ram_q2 is written into the buffer tail that edge. The buffer never overflows because of the issue rule.
- Output:
  - out_valid = (out_count != 0); out_data = buffer head.
  - Pop and capture in the same edge: the buffer shifts and appends.
  - Order is strictly FIFO.
- Read/write hazard: a word written at edge E is counted only after E, so it is never read at E. Port 2 therefore never reads an address being written in the same cycle.
- Latency:
  - Into an empty FIFO with out_ready=1, the word accepted at edge E0 is read-issued at E1 and captured at E2.
  - out_valid is therefore high after E2.
  - Sustained throughput is 1 word/cycle in and out.
- Full: capacity is 2**ADDR_W + 2 words. A write at in_ready=0 is ignored with no pointer change.
- Empty: out_valid=0; a pop attempt has no effect.
- fill_level:
  - Updated per edge, +accept, -pop.
  - Equals ram_count + inflight + out_count.
  - almost_full is registered from the next fill_level.
- Reset mid-operation: all in-flight and buffered data are discarded. A ram_q2 arriving the cycle after reset release is ignored.

Test Plan:
(All with ADDR_W=3, depth 8, AFULL_TH=6.)
- Reset, then write 0x0001 with out_ready=1 -> out_valid rises 2 edges after accept, out_data=0x0001, fill_level returns to 0 after pop.
- Write 0x0010..0x0019 with out_ready=0 -> 10 accepted. in_ready=0 after the 10th. fill_level=10, almost_full=1. An 11th write is ignored.
- Drain the full FIFO with out_ready=1 -> 0x0010..0x0019 in order, one per cycle once started, no duplicates. out_valid=0 after the last.
- Continuous write and read for 40 words (pointers wrap 5 times) -> output equals the input sequence. ram_w_en2 always 0. Port 2 never reads wr_ptr on the write edge.
- Random in_valid/out_ready toggling for 500 cycles -> scoreboard match. fill_level = accepts − pops every cycle.
- Assert rst_n low with 5 words queued and a read in flight -> out_valid=0 and fill_level=0 immediately. After release, a new word 0x00AA is the first output.
